// File: rtl/pipe_skid_rx_pkg.sv
// Shared definitions for the pipeline-register receive skid buffer:
// state encoding, default word width and the flush drop-count helper.
package pipe_skid_rx_pkg;

   localparam int DEF_WIDTH = 24;

   // Encoding doubles as the occupancy value (number of words held).
   typedef enum logic [1:0] {
      ST_EMPTY = 2'd0,
      ST_ONE   = 2'd1,
      ST_FULL  = 2'd2
   } state_t;

   // Words lost to a flush: what was held, minus a word leaving this cycle
   // (that one is delivered), plus a word arriving this cycle.
   function automatic logic [1:0] drop_calc(input logic [1:0] occ,
                                            input logic       emit,
                                            input logic       accept);
      logic [2:0] total;
      total = {1'b0, occ} + {2'b00, accept} - {2'b00, emit};
      return total[1:0];
   endfunction

endpackage

// File: rtl/pipe_skid_rx_sat_counter.sv
// Saturating up-counter adding 0..2 per cycle; sticks at all-ones.
module sat_counter #(
   parameter int CNT_W = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [1:0]       inc,
   output logic [CNT_W-1:0] count
);

   logic [CNT_W-1:0] count_r;
   logic [CNT_W:0]   sum_s;
   logic [CNT_W-1:0] next_s;

   // Add with one carry bit so an overflow can be detected and clamped.
   always_comb begin
      sum_s = {1'b0, count_r} + {{(CNT_W-1){1'b0}}, inc};
      if (sum_s[CNT_W]) begin
         next_s = {CNT_W{1'b1}};
      end else begin
         next_s = sum_s[CNT_W-1:0];
      end
   end

   // Counter register, cleared only by reset.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         count_r <= {CNT_W{1'b0}};
      end else begin
         count_r <= next_s;
      end
   end

   assign count = count_r;

endmodule

// File: rtl/pipe_skid_rx.sv
// Receive side of the stage-to-stage pipeline register: two-entry skid
// buffer (main + skid) so the upstream ready comes straight from a flop,
// with a synchronous flush and a saturating count of flushed words.
module pipe_skid_rx
   import pipe_skid_rx_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH,
   parameter int CNT_W = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [WIDTH-1:0] in_data,
   input  logic             in_valid,
   output logic             in_ready,
   output logic [WIDTH-1:0] out_data,
   output logic             out_valid,
   input  logic             out_ready,
   input  logic             flush,
   output logic [1:0]       occupancy,
   output logic [CNT_W-1:0] drop_count
);

   state_t           state_r;
   logic [WIDTH-1:0] main_r;
   logic [WIDTH-1:0] skid_r;
   logic             out_valid_r;
   logic             in_ready_r;
   logic             accept_s;
   logic             emit_s;
   logic [1:0]       drop_s;

   assign accept_s = in_valid & in_ready_r;
   assign emit_s   = out_valid_r & out_ready;

   // Number of words a flush throws away this cycle (zero when not flushing).
   always_comb begin
      drop_s = 2'd0;
      if (flush) begin
         drop_s = drop_calc(state_r, emit_s, accept_s);
      end else begin
         drop_s = 2'd0;
      end
   end

   // Skid FSM with datapath; ready/valid are kept as their own flops so no
   // combinational path reaches them from out_ready or in_valid.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_r     <= ST_EMPTY;
         main_r      <= {WIDTH{1'b0}};
         skid_r      <= {WIDTH{1'b0}};
         out_valid_r <= 1'b0;
         in_ready_r  <= 1'b1;
      end else if (flush) begin
         // Only validity is dropped; data registers keep their contents.
         state_r     <= ST_EMPTY;
         out_valid_r <= 1'b0;
         in_ready_r  <= 1'b1;
      end else begin
         case (state_r)
            ST_EMPTY: begin
               if (accept_s) begin
                  main_r      <= in_data;
                  state_r     <= ST_ONE;
                  out_valid_r <= 1'b1;
                  in_ready_r  <= 1'b1;
               end else begin
                  state_r     <= ST_EMPTY;
               end
            end
            ST_ONE: begin
               if (accept_s && emit_s) begin
                  main_r      <= in_data;
                  state_r     <= ST_ONE;
               end else if (accept_s) begin
                  skid_r      <= in_data;
                  state_r     <= ST_FULL;
                  in_ready_r  <= 1'b0;
               end else if (emit_s) begin
                  state_r     <= ST_EMPTY;
                  out_valid_r <= 1'b0;
               end else begin
                  state_r     <= ST_ONE;
               end
            end
            ST_FULL: begin
               if (emit_s) begin
                  main_r      <= skid_r;
                  state_r     <= ST_ONE;
                  in_ready_r  <= 1'b1;
               end else begin
                  state_r     <= ST_FULL;
               end
            end
            default: begin
               state_r     <= ST_EMPTY;
               out_valid_r <= 1'b0;
               in_ready_r  <= 1'b1;
            end
         endcase
      end
   end

   sat_counter #(.CNT_W(CNT_W)) u_drop_cnt (
      .clk   (clk),
      .reset (reset),
      .inc   (drop_s),
      .count (drop_count)
   );

   assign in_ready  = in_ready_r;
   assign out_valid = out_valid_r;
   assign out_data  = main_r;
   assign occupancy = state_r;

endmodule

// File: tb/tb_pipe_skid_rx.sv
// Scoreboard bench for pipe_skid_rx: stimulus pushes expected words, a
// negedge monitor pops and compares on every downstream handshake.
module tb_pipe_skid_rx;

   logic        clk = 1'b0;
   logic        reset;
   logic [23:0] in_data;
   logic        in_valid;
   logic        in_ready;
   logic [23:0] out_data;
   logic        out_valid;
   logic        out_ready;
   logic        flush;
   logic [1:0]  occupancy;
   logic [7:0]  drop_count;

   int checks   = 0;
   int failures = 0;
   logic [23:0] exp_q[$];
   int          exp_drop;

   pipe_skid_rx dut (
      .clk        (clk),
      .reset      (reset),
      .in_data    (in_data),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .out_data   (out_data),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .flush      (flush),
      .occupancy  (occupancy),
      .drop_count (drop_count)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Drive one upstream word for one cycle; expect tells the scoreboard
   // whether this word should eventually appear downstream.
   task automatic send(input logic [23:0] d, input bit expect_out);
      in_data  = d;
      in_valid = 1'b1;
      if (expect_out) exp_q.push_back(d);
      step();
      in_valid = 1'b0;
   endtask

   // Monitor: every downstream handshake must match the head of the queue.
   always @(negedge clk) begin
      if (!reset && out_valid && out_ready) begin
         checks++;
         if (exp_q.size() == 0) begin
            failures++;
            $display("FAIL emit_unexpected: got 0x%0h expected none", out_data);
         end else begin
            logic [23:0] e;
            e = exp_q.pop_front();
            if (out_data !== e) begin
               failures++;
               $display("FAIL emit_data: got 0x%0h expected 0x%0h", out_data, e);
            end
         end
      end
   end

   initial begin
      reset = 1'b1; in_data = 24'h0; in_valid = 1'b0; out_ready = 1'b0; flush = 1'b0;
      exp_drop = 0;
      #2;
      check("rst_in_ready", in_ready, 1);
      check("rst_out_valid", out_valid, 0);
      check("rst_out_data", out_data, 0);
      check("rst_occ", occupancy, 0);
      check("rst_drop", drop_count, 0);
      @(negedge clk);
      reset = 1'b0;

      // 1: streaming, one word per cycle
      out_ready = 1'b1;
      for (int i = 1; i <= 5; i++) begin
         in_data = 24'(i); in_valid = 1'b1; exp_q.push_back(24'(i));
         step();
         check("stream_occ", occupancy, 1);
         check("stream_in_ready", in_ready, 1);
         check("stream_out_data", out_data, i);
      end
      in_valid = 1'b0;
      step();
      check("stream_drain_occ", occupancy, 0);

      // 2: backpressure fills the skid, then drains in order
      out_ready = 1'b0;
      send(24'hABCDEF, 1'b1);
      send(24'h123456, 1'b1);
      check("bp_occ", occupancy, 2);
      check("bp_in_ready", in_ready, 0);
      check("bp_hold", out_data, 24'hABCDEF);
      step();
      check("bp_hold2", out_data, 24'hABCDEF);
      out_ready = 1'b1;
      step();
      check("bp_occ_after1", occupancy, 1);
      check("bp_ready_after1", in_ready, 1);
      check("bp_data_after1", out_data, 24'h123456);
      step();
      check("bp_occ_drained", occupancy, 0);
      out_ready = 1'b0;

      // flush with one held word, no emit: one word dropped
      send(24'h000055, 1'b0);
      flush = 1'b1; step(); flush = 1'b0;
      exp_drop = 1;
      check("fl1_drop", drop_count, exp_drop);
      check("fl1_occ", occupancy, 0);

      // 3: flush while FULL, in_valid high (in_ready low so no accept): +2
      send(24'h000011, 1'b0);
      send(24'h000022, 1'b0);
      in_data = 24'h0000AA; in_valid = 1'b1; flush = 1'b1;
      step();
      flush = 1'b0; in_valid = 1'b0;
      exp_drop = 3;
      check("fl3_valid", out_valid, 0);
      check("fl3_occ", occupancy, 0);
      check("fl3_drop", drop_count, exp_drop);

      // 4: flush in ONE with emit: word is delivered, not dropped
      send(24'h000077, 1'b1);
      out_ready = 1'b1; flush = 1'b1;
      step();
      flush = 1'b0; out_ready = 1'b0;
      check("fl4_drop", drop_count, exp_drop);
      check("fl4_occ", occupancy, 0);
      check("fl4_delivered", exp_q.size(), 0);

      // flush in EMPTY with an accept: the incoming word is dropped
      in_data = 24'h000099; in_valid = 1'b1; flush = 1'b1;
      step();
      flush = 1'b0; in_valid = 1'b0;
      exp_drop = 4;
      check("fl_acc_drop", drop_count, exp_drop);
      check("fl_acc_occ", occupancy, 0);

      // 5: saturation with repeated full flushes (+2 each)
      for (int k = 0; k < 128; k++) begin
         send(24'(k), 1'b0);
         send(24'(k + 1000), 1'b0);
         flush = 1'b1; step(); flush = 1'b0;
         exp_drop = (exp_drop + 2 > 255) ? 255 : exp_drop + 2;
         check("sat_drop", drop_count, exp_drop);
      end
      check("sat_final", drop_count, 255);

      // 6: async reset mid-FULL, pulsed between edges
      send(24'h0000C1, 1'b0);
      send(24'h0000C2, 1'b0);
      check("pre_rst_occ", occupancy, 2);
      #2 reset = 1'b1;
      #1;
      check("arst_valid", out_valid, 0);
      check("arst_occ", occupancy, 0);
      check("arst_drop", drop_count, 0);
      check("arst_in_ready", in_ready, 1);
      #1 reset = 1'b0;
      step();
      check("post_rst_occ", occupancy, 0);

      // traffic resumes after reset
      out_ready = 1'b1;
      send(24'h0BEEF0, 1'b1);
      step();
      check("post_rst_drained", exp_q.size(), 0);
      check("post_rst_drop", drop_count, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
